packet_assembler_2: RTL and testbench

- Receives the 2-flit NoC flit stream from a router output port and reassembles each head/tail pair into one WIDTH_PKT-bit packet.
- Sits directly upstream of the 2-flit depacketizer and presents the packet/valid/ready interface that the depacketizer consumes.
- Provides elastic buffering: sustains one flit per cycle under no backpressure and performs protocol checks on flit order and VC.

---
 rtl/packet_assembler_2.sv | 143 ++++++++++++++
 tb/tb_packet_assembler_2.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler_2.sv
// rtl/packet_assembler_2.sv - reassembles head/tail NoC flit pairs into packets (optional PACKET_ASSEMBLER_ERR_CNT_EN)
module packet_assembler_2 #(
  parameter int WIDTH_PKT        = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_PKT/2-1:0] i_flit_in,
  input  logic                   i_valid_in,
  output logic                   i_ready_out,
  output logic [WIDTH_PKT-1:0]   o_packet_out,
  output logic                   o_valid_out,
  input  logic                   o_ready_in,
  output logic                   o_err_out
`ifdef PACKET_ASSEMBLER_ERR_CNT_EN
  ,
  output logic [15:0]            o_err_cnt_out
`endif
);

  localparam int WIDTH_FLIT = WIDTH_PKT / 2;
  localparam int BIT_VALID  = WIDTH_FLIT - 1;
  localparam int BIT_HEAD   = WIDTH_FLIT - 2;
  localparam int BIT_TAIL   = WIDTH_FLIT - 3;
  localparam int VC_MSB     = WIDTH_FLIT - 4;

  // Control bits, VC and head destination must all fit inside one flit
  if ((WIDTH_PKT % 2) != 0 || (3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH) > WIDTH_FLIT) begin : g_bad_cfg
    $error("packet_assembler_2: invalid WIDTH_PKT / field widths");
  end

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    HAVE_HEAD = 2'd1,
    FULL      = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH_FLIT-1:0] head_q, head_d;
  logic [WIDTH_PKT-1:0]  packet_q, packet_d;
  logic                  err_q, err_d;

  state_t base_state;
  logic   accept;
  logic   f_valid, f_head, f_tail, vc_match;

  assign i_ready_out  = (state_q != FULL) || o_ready_in;
  assign accept       = i_valid_in && i_ready_out;
  assign f_valid      = i_flit_in[BIT_VALID];
  assign f_head       = i_flit_in[BIT_HEAD];
  assign f_tail       = i_flit_in[BIT_TAIL];
  assign vc_match     = (i_flit_in[VC_MSB -: VC_ADDRESS_WIDTH] == head_q[VC_MSB -: VC_ADDRESS_WIDTH]);
  assign o_packet_out = packet_q;
  assign o_valid_out  = (state_q == FULL);
  assign o_err_out    = err_q;

  // Next-state: a draining FULL behaves as EMPTY for the flit arriving in the same cycle
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    packet_d   = packet_q;
    err_d      = 1'b0;
    base_state = state_q;
    if (state_q == FULL && o_ready_in) begin
      base_state = EMPTY;
      state_d    = EMPTY;
    end
    if (accept && f_valid) begin
      case (base_state)
        EMPTY: begin
          if (f_head) begin
            if (f_tail) begin
              packet_d = {i_flit_in, {WIDTH_FLIT{1'b0}}};
              state_d  = FULL;
            end else begin
              head_d  = i_flit_in;
              state_d = HAVE_HEAD;
            end
          end else if (f_tail) begin
            err_d = 1'b1;
          end
        end
        HAVE_HEAD: begin
          if (f_head) begin
            err_d = 1'b1;
            if (f_tail) begin
              packet_d = {i_flit_in, {WIDTH_FLIT{1'b0}}};
              state_d  = FULL;
            end else begin
              head_d = i_flit_in;
            end
          end else if (f_tail) begin
            if (vc_match) begin
              packet_d = {head_q, i_flit_in};
              state_d  = FULL;
            end else begin
              err_d   = 1'b1;
              state_d = EMPTY;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State, head, packet and error-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      packet_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      packet_q <= packet_d;
      err_q    <= err_d;
    end
  end

`ifdef PACKET_ASSEMBLER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of error pulses
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign o_err_cnt_out = err_cnt_q;
`endif

endmodule

// File: tb/tb_packet_assembler_2.sv
// tb/tb_packet_assembler_2.sv - self-checking bench for packet_assembler_2
module tb_packet_assembler_2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] i_flit_in = '0;
  logic        i_valid_in = 1'b0;
  logic        i_ready_out;
  logic [35:0] o_packet_out;
  logic        o_valid_out;
  logic        o_ready_in = 1'b1;
  logic        o_err_out;
`ifdef PACKET_ASSEMBLER_ERR_CNT_EN
  logic [15:0] o_err_cnt_out;
`endif

  packet_assembler_2 dut (
    .clk          (clk),
    .rst          (rst),
    .i_flit_in    (i_flit_in),
    .i_valid_in   (i_valid_in),
    .i_ready_out  (i_ready_out),
    .o_packet_out (o_packet_out),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in),
    .o_err_out    (o_err_out)
`ifdef PACKET_ASSEMBLER_ERR_CNT_EN
    ,
    .o_err_cnt_out(o_err_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pending head plus queue of packets the DUT must present, in order
  logic [35:0] exp_q[$];
  bit          pend_head = 0;
  logic [17:0] head_v = '0;
  bit          exp_err = 0;
  bit          chk_en = 0;
  int          err_obs = 0;
  int          cyc_g = 0;
  bit          last_acc = 0;
  logic [35:0] out_pkts[$];
  int          hs_cyc[$];
  logic [17:0] fl[$];

  function automatic void chk(input string n, input logic [35:0] a, input logic [35:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endfunction

  function automatic logic [17:0] mk(input bit h, input bit t, input bit vc,
                                     input logic [3:0] d, input logic [9:0] p);
    return {1'b1, h, t, vc, d, p};
  endfunction

  function automatic void model_flit(input logic [17:0] f);
    if (!f[17]) return;
    if (f[16]) begin
      if (pend_head) exp_err = 1;
      if (f[15]) begin
        exp_q.push_back({f, 18'h0});
        pend_head = 0;
      end else begin
        pend_head = 1;
        head_v = f;
      end
    end else if (f[15]) begin
      if (pend_head && f[14] == head_v[14]) exp_q.push_back({head_v, f});
      else exp_err = 1;
      pend_head = 0;
    end else if (pend_head) begin
      exp_err = 1;
    end
  endfunction

  // Compare process: every cycle, after inputs have settled
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("err_out", {35'h0, o_err_out}, {35'h0, exp_err});
      chk("valid_out", {35'h0, o_valid_out}, {35'h0, (exp_q.size() != 0)});
      chk("ready_out", {35'h0, i_ready_out}, {35'h0, (exp_q.size() == 0 || o_ready_in)});
      if (exp_q.size() != 0) chk("packet_out", o_packet_out, exp_q[0]);
      if (o_err_out) err_obs++;
    end
  end

  // One clock: sample handshakes, cross the edge, advance the model
  task automatic step();
    bit acc, hs;
    logic [17:0] f;
    #1;
    acc = i_valid_in && i_ready_out;
    hs  = o_valid_out && o_ready_in;
    f   = i_flit_in;
    if (hs && !rst) begin
      out_pkts.push_back(o_packet_out);
      hs_cyc.push_back(cyc_g);
    end
    @(posedge clk);
    exp_err = 0;
    if (rst) begin
      exp_q.delete();
      pend_head = 0;
      last_acc = 0;
    end else begin
      if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) model_flit(f);
      last_acc = acc;
    end
    cyc_g++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    i_valid_in = 0;
    repeat (n) step();
    rst = 0;
  endtask

  // Drive fl[] one flit per cycle; o_ready_in held low until rel_cyc
  task automatic run_stream(input int rel_cyc, input int max_cyc, output int acc_before_rel);
    int idx = 0;
    int cyc = 0;
    acc_before_rel = 0;
    out_pkts.delete();
    hs_cyc.delete();
    while ((idx < fl.size() || exp_q.size() != 0) && cyc < max_cyc) begin
      o_ready_in = (cyc >= rel_cyc);
      i_valid_in = (idx < fl.size());
      i_flit_in  = (idx < fl.size()) ? fl[idx] : 18'h0;
      step();
      if (last_acc) begin
        idx++;
        if (cyc < rel_cyc) acc_before_rel++;
      end
      cyc++;
    end
    if (cyc >= max_cyc) chk("stream_timeout", 36'(cyc), 36'(max_cyc - 1));
    i_valid_in = 0;
    o_ready_in = 1;
    fl.delete();
  endtask

  task automatic idle(input int n);
    i_valid_in = 0;
    repeat (n) step();
  endtask

  initial begin
    int e0, ab;
    @(negedge clk);

    // Reset state
    do_reset(2);
    chk_en = 1;
    #2;
    chk("rst_packet", o_packet_out, 36'h0);
    chk("rst_valid", {35'h0, o_valid_out}, 36'h0);
    chk("rst_ready", {35'h0, i_ready_out}, 36'h1);
    chk("rst_err", {35'h0, o_err_out}, 36'h0);
    @(negedge clk);

    // Basic assembly
    e0 = err_obs;
    fl = '{18'b11_0_0_0101_0010101011, 18'b1_0_1_0_0000_0011001101};
    run_stream(0, 50, ab);
    chk("basic_count", 36'(out_pkts.size()), 36'd1);
    if (out_pkts.size() > 0)
      chk("basic_pkt", out_pkts[0], {18'b11_0_0_0101_0010101011, 18'b1_0_1_0_0000_0011001101});
    chk("basic_err", 36'(err_obs - e0), 36'd0);

    // Backpressure: three packets, downstream released at cycle 8
    fl = '{mk(1,0,0,4'h1,10'h011), mk(0,1,0,4'h0,10'h012),
           mk(1,0,1,4'h2,10'h021), mk(0,1,1,4'h0,10'h022),
           mk(1,0,0,4'h3,10'h031), mk(0,1,0,4'h0,10'h032)};
    run_stream(8, 100, ab);
    chk("bp_accept_held", 36'(ab), 36'd2);
    chk("bp_count", 36'(out_pkts.size()), 36'd3);
    if (out_pkts.size() == 3) begin
      chk("bp_pkt0", out_pkts[0], {mk(1,0,0,4'h1,10'h011), mk(0,1,0,4'h0,10'h012)});
      chk("bp_pkt1", out_pkts[1], {mk(1,0,1,4'h2,10'h021), mk(0,1,1,4'h0,10'h022)});
      chk("bp_pkt2", out_pkts[2], {mk(1,0,0,4'h3,10'h031), mk(0,1,0,4'h0,10'h032)});
      chk("bp_gap01", 36'(hs_cyc[1] - hs_cyc[0]), 36'd2);
      chk("bp_gap12", 36'(hs_cyc[2] - hs_cyc[1]), 36'd2);
    end

    // Orphan tail then a good pair
    e0 = err_obs;
    fl = '{mk(0,1,0,4'h0,10'h3FF), mk(1,0,1,4'h9,10'h101), mk(0,1,1,4'h0,10'h102)};
    run_stream(0, 50, ab);
    chk("orphan_err", 36'(err_obs - e0), 36'd1);
    chk("orphan_count", 36'(out_pkts.size()), 36'd1);
    if (out_pkts.size() > 0)
      chk("orphan_pkt", out_pkts[0], {mk(1,0,1,4'h9,10'h101), mk(0,1,1,4'h0,10'h102)});

    // Head restart: head A, head B, tail with B's VC
    e0 = err_obs;
    fl = '{mk(1,0,0,4'hA,10'h0AA), mk(1,0,1,4'hB,10'h0BB), mk(0,1,1,4'h0,10'h0CC)};
    run_stream(0, 50, ab);
    chk("restart_err", 36'(err_obs - e0), 36'd1);
    chk("restart_count", 36'(out_pkts.size()), 36'd1);
    if (out_pkts.size() > 0)
      chk("restart_pkt", out_pkts[0], {mk(1,0,1,4'hB,10'h0BB), mk(0,1,1,4'h0,10'h0CC)});

    // VC mismatch, then a tail proving the assembler went back to empty
    e0 = err_obs;
    fl = '{mk(1,0,0,4'h7,10'h077), mk(0,1,1,4'h0,10'h078), mk(0,1,0,4'h0,10'h079)};
    run_stream(0, 50, ab);
    idle(1);
    chk("vcmis_err", 36'(err_obs - e0), 36'd2);
    chk("vcmis_count", 36'(out_pkts.size()), 36'd0);

    // Single-flit packet
    fl = '{mk(1,1,0,4'hC,10'h155)};
    run_stream(0, 50, ab);
    chk("single_count", 36'(out_pkts.size()), 36'd1);
    if (out_pkts.size() > 0) chk("single_pkt", out_pkts[0], {mk(1,1,0,4'hC,10'h155), 18'h0});

    // Reset in HAVE_HEAD; following tail is an orphan
    fl = '{mk(1,0,0,4'h4,10'h044)};
    run_stream(0, 50, ab);
    do_reset(1);
    #2;
    chk("midrst_ready", {35'h0, i_ready_out}, 36'h1);
    chk("midrst_packet", o_packet_out, 36'h0);
    @(negedge clk);
    e0 = err_obs;
    fl = '{mk(0,1,0,4'h0,10'h045)};
    run_stream(0, 50, ab);
    idle(1);
    chk("midrst_err", 36'(err_obs - e0), 36'd1);
    chk("midrst_count", 36'(out_pkts.size()), 36'd0);

`ifdef PACKET_ASSEMBLER_ERR_CNT_EN
    // Error counter: three orphan tails, then reset
    do_reset(1);
    fl = '{mk(0,1,0,4'h0,10'h001), mk(0,1,0,4'h0,10'h002), mk(0,1,0,4'h0,10'h003)};
    run_stream(0, 50, ab);
    idle(3);
    #2;
    chk("errcnt_3", {20'h0, o_err_cnt_out}, 36'd3);
    @(negedge clk);
    do_reset(1);
    #2;
    chk("errcnt_rst", {20'h0, o_err_cnt_out}, 36'd0);
    @(negedge clk);
`endif

    idle(2);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
